// File: rtl/noc_rd_master_if.sv
// Bundle of command, noc read-port and output-stream signals for noc_rd_master.
// The master modport is the block's view; slave is the environment's view.
interface noc_rd_master_if #(
   parameter int DATA_WIDTH_MSB = 15,
   parameter int ADDR_WIDTH_MSB = 15
);
   logic                    cmd_start;
   logic [ADDR_WIDTH_MSB:0] cmd_addr;
   logic [7:0]              cmd_len;
   logic                    cmd_busy;
   logic                    cmd_done;

   logic                    noc_rd_valid;
   logic                    noc_rd_ready;
   logic [ADDR_WIDTH_MSB:0] noc_rd_addr;
   logic [DATA_WIDTH_MSB:0] noc_rd_data;

   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_WIDTH_MSB:0] out_data;

   modport master (
      input  cmd_start, cmd_addr, cmd_len, noc_rd_ready, noc_rd_data, out_ready,
      output cmd_busy, cmd_done, noc_rd_valid, noc_rd_addr, out_valid, out_data
   );

   modport slave (
      output cmd_start, cmd_addr, cmd_len, noc_rd_ready, noc_rd_data, out_ready,
      input  cmd_busy, cmd_done, noc_rd_valid, noc_rd_addr, out_valid, out_data
   );
endinterface

// File: rtl/noc_rd_master.sv
// Burst read master: issues sequential word reads on a noc port and streams the
// returned words through a first-word-fall-through buffer.
module noc_rd_master #(
   parameter int DATA_WIDTH_MSB = 15,
   parameter int ADDR_WIDTH_MSB = 15,
   parameter int FIFO_DEPTH     = 4
) (
   input logic             clk,
   input logic             rst,
   noc_rd_master_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] ALMOST_CNT = (PTR_W+1)'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, REQ, STALL, DRAIN} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH_MSB:0] addr_cnt;
   logic [7:0]              rem_cnt;
   logic                    done_q;

   logic [DATA_WIDTH_MSB:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [PTR_W:0]          count;
   logic                    push, pop, empty, full;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   // REQ is only ever entered with a free entry, so a push never meets a full buffer.
   assign push  = (state == REQ) && bus.noc_rd_ready;
   assign pop   = !empty && bus.out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.cmd_start) state_nxt = (bus.cmd_len != '0) ? REQ : DRAIN;
         REQ:   if (push) begin
                   if (rem_cnt == 8'd1)                 state_nxt = DRAIN;
                   else if (count == ALMOST_CNT && !pop) state_nxt = STALL;
                end
         STALL: if (!full)  state_nxt = REQ;
         DRAIN: if (empty)  state_nxt = IDLE;
         default:           state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_cnt <= '0;
         rem_cnt  <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == DRAIN) && empty;
         if (state == IDLE && bus.cmd_start) begin
            addr_cnt <= bus.cmd_addr;
            rem_cnt  <= bus.cmd_len;
         end else if (push) begin
            addr_cnt <= addr_cnt + 1'b1;
            rem_cnt  <= rem_cnt - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.noc_rd_data;
   end

   assign bus.cmd_busy     = (state != IDLE);
   assign bus.cmd_done     = done_q;
   assign bus.noc_rd_valid = (state == REQ);
   assign bus.noc_rd_addr  = addr_cnt;
   assign bus.out_valid    = !empty;
   // Head word is masked while empty so a flushed buffer presents zero data.
   assign bus.out_data     = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_noc_rd_master.sv
// Directed bench for noc_rd_master: table of bursts plus reset sequences.
module tb_noc_rd_master;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   noc_rd_master_if #(.DATA_WIDTH_MSB(15), .ADDR_WIDTH_MSB(15)) bus();

   noc_rd_master #(.DATA_WIDTH_MSB(15), .ADDR_WIDTH_MSB(15), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory model: each word's data is its address scrambled with a constant.
   localparam logic [15:0] SCRAMBLE = 16'hC3A5;
   assign bus.noc_rd_data = bus.noc_rd_addr ^ SCRAMBLE;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
      int          noc_wait;
      int          restart;
      int          out_hold;
      int          exp_hold_grants;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
      int          exp_grants;
   } vec_t;

   vec_t tv[6];

   task automatic run_burst(input vec_t v);
      logic [15:0] exp_addr;
      logic [15:0] q[$];
      logic [15:0] e;
      logic [15:0] first, last;
      int grants, words, done_cyc;
      bit finished;
      exp_addr = v.addr;
      grants   = 0;
      words    = 0;
      done_cyc = -1;
      finished = 0;
      first    = '0;
      last     = '0;

      @(negedge clk);
      bus.cmd_addr     = v.addr;
      bus.cmd_len      = v.len;
      bus.cmd_start    = 1'b1;
      bus.noc_rd_ready = 1'b0;
      bus.out_ready    = 1'b0;

      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         @(negedge clk);
         bus.cmd_start = (v.restart != 0 && cyc == 2);
         if (bus.cmd_start) begin
            bus.cmd_addr = 16'h7777;
            bus.cmd_len  = 8'd9;
         end
         bus.noc_rd_ready = (cyc >= v.noc_wait);
         if (v.out_hold > 0 && cyc == v.out_hold) begin
            check("hold_grants", grants, v.exp_hold_grants);
            check("stall_valid", bus.noc_rd_valid, 0);
            check("stall_busy", bus.cmd_busy, 1);
         end
         bus.out_ready = (cyc >= v.out_hold);

         if (bus.noc_rd_valid) begin
            check("rd_addr", bus.noc_rd_addr, exp_addr);
            if (bus.noc_rd_ready) begin
               if (grants == 0) first = exp_addr;
               last = exp_addr;
               q.push_back(exp_addr ^ SCRAMBLE);
               exp_addr = exp_addr + 16'd1;
               grants++;
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
            check("out_data", bus.out_data, e);
            words++;
         end
         if (bus.cmd_done) begin
            finished = 1;
            done_cyc = cyc;
            check("busy_at_done", bus.cmd_busy, 0);
         end
      end

      check("done_seen", finished, 1);
      check("grants", grants, v.exp_grants);
      check("words", words, v.exp_grants);
      check("left_in_queue", q.size(), 0);
      if (v.exp_grants > 0) begin
         check("first_addr", first, v.exp_first);
         check("last_addr", last, v.exp_last);
      end else begin
         check("zero_len_done_cyc", (done_cyc >= 0 && done_cyc <= 2), 1);
      end

      @(negedge clk);
      bus.cmd_start = 1'b0;
      check("done_one_cycle", bus.cmd_done, 0);
      check("idle_busy", bus.cmd_busy, 0);
      check("idle_valid", bus.noc_rd_valid, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, bus.cmd_busy, 0);
      check({tag, "_done"}, bus.cmd_done, 0);
      check({tag, "_valid"}, bus.noc_rd_valid, 0);
      check({tag, "_addr"}, bus.noc_rd_addr, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{addr:16'h0010, len:8'd3, noc_wait:0, restart:0, out_hold:0,  exp_hold_grants:0,
                exp_first:16'h0010, exp_last:16'h0012, exp_grants:3};
      tv[1] = '{addr:16'hFFFE, len:8'd4, noc_wait:0, restart:0, out_hold:0,  exp_hold_grants:0,
                exp_first:16'hFFFE, exp_last:16'h0001, exp_grants:4};
      tv[2] = '{addr:16'h1234, len:8'd0, noc_wait:0, restart:0, out_hold:0,  exp_hold_grants:0,
                exp_first:16'h0000, exp_last:16'h0000, exp_grants:0};
      tv[3] = '{addr:16'h0100, len:8'd5, noc_wait:5, restart:1, out_hold:0,  exp_hold_grants:0,
                exp_first:16'h0100, exp_last:16'h0104, exp_grants:5};
      tv[4] = '{addr:16'h0040, len:8'd8, noc_wait:0, restart:0, out_hold:12, exp_hold_grants:4,
                exp_first:16'h0040, exp_last:16'h0047, exp_grants:8};
      tv[5] = '{addr:16'h0200, len:8'd1, noc_wait:0, restart:0, out_hold:0,  exp_hold_grants:0,
                exp_first:16'h0200, exp_last:16'h0200, exp_grants:1};

      rst              = 1'b1;
      bus.cmd_start    = 1'b0;
      bus.cmd_addr     = '0;
      bus.cmd_len      = '0;
      bus.noc_rd_ready = 1'b0;
      bus.out_ready    = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_burst(tv[i]);

      // Reset in the middle of a 6-word burst, with two words still buffered.
      @(negedge clk);
      bus.cmd_addr     = 16'h0300;
      bus.cmd_len      = 8'd6;
      bus.cmd_start    = 1'b1;
      bus.noc_rd_ready = 1'b1;
      bus.out_ready    = 1'b0;
      @(negedge clk);
      bus.cmd_start = 1'b0;
      check("mid_addr0", bus.noc_rd_addr, 16'h0300);
      @(negedge clk);
      check("mid_addr1", bus.noc_rd_addr, 16'h0301);
      @(negedge clk);
      check("mid_out_valid", bus.out_valid, 1);
      check("mid_out_data", bus.out_data, 16'h0300 ^ SCRAMBLE);
      check("mid_busy", bus.cmd_busy, 1);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_valid", bus.noc_rd_valid, 0);
         check("post_rst_busy", bus.cmd_busy, 0);
         check("post_rst_out_valid", bus.out_valid, 0);
      end

      run_burst(tv[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
